// File: rtl/result_collector.sv
// =============================================================================
// result_collector: buffers dot-product results, then drains them in row-major
// order over a valid/ready stream. Revision 1.0
// =============================================================================
`default_nettype none

module result_collector #(
    parameter int n = 8,
    parameter int m = 8,
    parameter int w = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         loaddim,
    input  logic [n-1:0] dim0,
    input  logic [n-1:0] dim2,
    input  logic         valid,
    input  logic [w-1:0] res_data,
    input  logic         done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [w-1:0] out_data,
    output logic [n-1:0] out_row,
    output logic [n-1:0] out_col,
    output logic         out_last,
    output logic         busy,
    output logic         drained,
    output logic         err_short,
    output logic         err_ovf
);

    localparam int CW = (2 * n > m + 1) ? 2 * n : m + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   dim2_q, dim2_d;
    logic [2*n-1:0] total_q, total_d;
    logic [m:0]     wr_cnt_q, wr_cnt_d;
    logic [m:0]     rd_cnt_q, rd_cnt_d;
    logic [n-1:0]   row_q, row_d;
    logic [n-1:0]   col_q, col_d;
    logic           err_short_q, err_short_d;
    logic           err_ovf_q, err_ovf_d;
    logic           drained_q, drained_d;

    logic [w-1:0]   buf_q [2**m];

    logic [2*n-1:0] w_total;
    logic           w_room;
    logic           w_wr_en;
    logic           w_accept;
    logic           w_col_wrap;

    assign w_total    = {{n{1'b0}}, dim0} * {{n{1'b0}}, dim2};
    // wr_cnt[m] set means the buffer already holds 2^m words
    assign w_room     = (CW'(wr_cnt_q) < CW'(total_q)) && !wr_cnt_q[m];
    assign w_wr_en    = (state_q == S_COLLECT) && valid && w_room;
    assign w_col_wrap = (col_q == dim2_q - n'(1));

    assign out_valid  = (state_q == S_DRAIN) && (rd_cnt_q < wr_cnt_q);
    assign out_data   = buf_q[rd_cnt_q[m-1:0]];
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_last   = out_valid && (rd_cnt_q == wr_cnt_q - (m+1)'(1));
    assign w_accept   = out_valid && out_ready;
    assign busy       = (state_q != S_IDLE);
    assign drained    = drained_q;
    assign err_short  = err_short_q;
    assign err_ovf    = err_ovf_q;

    always_comb begin
        state_d     = state_q;
        dim2_d      = dim2_q;
        total_d     = total_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        err_short_d = err_short_q;
        err_ovf_d   = err_ovf_q;
        drained_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (loaddim) begin
                    state_d     = S_COLLECT;
                    dim2_d      = dim2;
                    total_d     = w_total;
                    wr_cnt_d    = '0;
                    rd_cnt_d    = '0;
                    row_d       = '0;
                    col_d       = '0;
                    err_short_d = 1'b0;
                    err_ovf_d   = 1'b0;
                end
            end
            S_COLLECT: begin
                if (valid) begin
                    if (w_room) begin
                        wr_cnt_d = wr_cnt_q + (m+1)'(1);
                        col_d    = w_col_wrap ? '0 : col_q + n'(1);
                        row_d    = w_col_wrap ? row_q + n'(1) : row_q;
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                end
                // row/col are reused as the read coordinates once draining starts
                if (done) begin
                    state_d  = S_DRAIN;
                    rd_cnt_d = '0;
                    row_d    = '0;
                    col_d    = '0;
                    if (CW'(wr_cnt_d) != CW'(total_q)) begin
                        err_short_d = 1'b1;
                    end
                    if (wr_cnt_d == '0) begin
                        drained_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (wr_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else if (w_accept) begin
                    rd_cnt_d = rd_cnt_q + (m+1)'(1);
                    col_d    = w_col_wrap ? '0 : col_q + n'(1);
                    row_d    = w_col_wrap ? row_q + n'(1) : row_q;
                    if (out_last) begin
                        state_d   = S_IDLE;
                        drained_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dim2_q      <= '0;
            total_q     <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            err_short_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            drained_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dim2_q      <= dim2_d;
            total_q     <= total_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            err_short_q <= err_short_d;
            err_ovf_q   <= err_ovf_d;
            drained_q   <= drained_d;
        end
    end

    // Storage is never reset; only words below wr_cnt are ever read
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            buf_q[wr_cnt_q[m-1:0]] <= res_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_result_collector.sv
// =============================================================================
// tb_result_collector: scoreboard bench for result_collector. Revision 1.0
// =============================================================================
`default_nettype none

module tb_result_collector;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  row;
        logic [7:0]  col;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        loaddim;
    logic [7:0]  dim0;
    logic [7:0]  dim2;
    logic        valid;
    logic [15:0] res_data;
    logic        done;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_row;
    logic [7:0]  out_col;
    logic        out_last;
    logic        busy;
    logic        drained;
    logic        err_short;
    logic        err_ovf;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    exp_cnt;
    int    exp_total;
    int    exp_dim2;
    bit    exp_ovf;

    result_collector #(.n(8), .m(8), .w(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .loaddim   (loaddim),
        .dim0      (dim0),
        .dim2      (dim2),
        .valid     (valid),
        .res_data  (res_data),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .drained   (drained),
        .err_short (err_short),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All stimulus is applied at a falling edge; outputs are sampled there too.
    task automatic start_job(input int d0, input int d2);
        loaddim = 1'b1;
        dim0    = d0[7:0];
        dim2    = d2[7:0];
        @(negedge clk);
        loaddim   = 1'b0;
        exp_cnt   = 0;
        exp_total = d0 * d2;
        exp_dim2  = d2;
        exp_ovf   = 1'b0;
        sb.delete();
    endtask

    task automatic send(input logic [15:0] d, input bit with_done);
        beat_t b;
        valid    = 1'b1;
        res_data = d;
        done     = with_done;
        if (exp_cnt < exp_total && exp_cnt < 256) begin
            b.data = d;
            b.row  = 8'(exp_cnt / exp_dim2);
            b.col  = 8'(exp_cnt % exp_dim2);
            b.last = 1'b0;
            sb.push_back(b);
            exp_cnt++;
        end else begin
            exp_ovf = 1'b1;
        end
        @(negedge clk);
        valid = 1'b0;
        done  = 1'b0;
        if (with_done && sb.size() > 0) sb[sb.size()-1].last = 1'b1;
    endtask

    task automatic end_job();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        if (sb.size() > 0) sb[sb.size()-1].last = 1'b1;
    endtask

    task automatic drain(input bit toggle, input string tag);
        beat_t       e;
        int          cyc     = 0;
        bit          fin     = 1'b0;
        bit          stalled = 1'b0;
        logic [32:0] held    = '0;
        while (!fin && cyc < 100) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (out_valid) begin
                if (stalled) begin
                    checks++;
                    if ({out_data, out_row, out_col, out_last} !== held) begin
                        failures++;
                        $display("FAIL %s hold: got %h expected %h", tag,
                                 {out_data, out_row, out_col, out_last}, held);
                    end
                end
                if (out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL %s extra beat: got data %0d expected none", tag, out_data);
                        fin = 1'b1;
                    end else begin
                        e = sb.pop_front();
                        if (out_data !== e.data || out_row !== e.row ||
                            out_col !== e.col || out_last !== e.last) begin
                            failures++;
                            $display("FAIL %s beat: got d=%0d r=%0d c=%0d l=%0b expected d=%0d r=%0d c=%0d l=%0b",
                                     tag, out_data, out_row, out_col, out_last,
                                     e.data, e.row, e.col, e.last);
                        end
                        fin = e.last;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = {out_data, out_row, out_col, out_last};
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (!fin || sb.size() != 0) begin
            failures++;
            $display("FAIL %s completion: got finished=%0b left=%0d expected finished=1 left=0",
                     tag, fin, sb.size());
        end
        checks++;
        if (drained !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s drained pulse: got drained=%0b busy=%0b out_valid=%0b expected 1 0 0",
                     tag, drained, busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (drained !== 1'b0) begin
            failures++;
            $display("FAIL %s drained width: got %0b expected 0", tag, drained);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; loaddim = 1'b0; dim0 = '0; dim2 = '0; valid = 1'b0;
        res_data = '0; done = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({out_valid, out_last, busy, drained, err_short, err_ovf} !== 6'b0) begin
            failures++;
            $display("FAIL reset outputs: got %b expected 000000",
                     {out_valid, out_last, busy, drained, err_short, err_ovf});
        end
    endtask

    task automatic test_basic(input int base, input bit toggle, input string tag);
        start_job(2, 3);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy in collect: got %0b expected 1", tag, busy);
        end
        for (int i = 0; i < 6; i++) send(16'(base + i), 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s out_valid in collect: got %0b expected 0", tag, out_valid);
        end
        end_job();
        checks++;
        if (err_short !== 1'b0 || err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL %s errors: got short=%0b ovf=%0b expected 0 0", tag, err_short, err_ovf);
        end
        drain(toggle, tag);
    endtask

    task automatic test_overflow();
        start_job(2, 2);
        for (int i = 0; i < 4; i++) send(16'(50 + i), 1'b0);
        send(16'd99, 1'b0);
        end_job();
        checks++;
        if (err_ovf !== exp_ovf || err_short !== 1'b0) begin
            failures++;
            $display("FAIL overflow flags: got ovf=%0b short=%0b expected ovf=%0b short=0",
                     err_ovf, err_short, exp_ovf);
        end
        drain(1'b0, "overflow");
        checks++;
        if (err_ovf !== 1'b1) begin
            failures++;
            $display("FAIL overflow sticky: got %0b expected 1", err_ovf);
        end
    endtask

    task automatic test_short();
        start_job(2, 2);
        checks++;
        if (err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL short clears ovf on loaddim: got %0b expected 0", err_ovf);
        end
        for (int i = 0; i < 3; i++) send(16'(70 + i), 1'b0);
        end_job();
        checks++;
        if (err_short !== 1'b1 || err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL short flags: got short=%0b ovf=%0b expected 1 0", err_short, err_ovf);
        end
        drain(1'b0, "short");
        checks++;
        if (err_short !== 1'b1) begin
            failures++;
            $display("FAIL short sticky: got %0b expected 1", err_short);
        end
    endtask

    task automatic test_empty();
        start_job(0, 3);
        end_job();
        checks++;
        if (out_valid !== 1'b0 || drained !== 1'b1 || busy !== 1'b1 || err_short !== 1'b0) begin
            failures++;
            $display("FAIL empty first drain cycle: got v=%0b dr=%0b busy=%0b short=%0b expected 0 1 1 0",
                     out_valid, drained, busy, err_short);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || drained !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty return idle: got v=%0b dr=%0b busy=%0b expected 0 0 0",
                     out_valid, drained, busy);
        end
    endtask

    task automatic test_coincident();
        start_job(1, 2);
        send(16'd5, 1'b0);
        send(16'd6, 1'b1);
        checks++;
        if (err_short !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL coincident entry: got short=%0b busy=%0b expected 0 1", err_short, busy);
        end
        drain(1'b0, "coincident");
    endtask

    task automatic test_reset_drain();
        beat_t e;
        start_job(2, 3);
        for (int i = 0; i < 6; i++) send(16'(20 + i), 1'b0);
        end_job();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_data !== e.data) begin
                failures++;
                $display("FAIL rst_drain beat: got v=%0b d=%0d expected v=1 d=%0d",
                         out_valid, out_data, e.data);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || drained !== 1'b0) begin
            failures++;
            $display("FAIL rst_drain idle: got v=%0b busy=%0b dr=%0b expected 0 0 0",
                     out_valid, busy, drained);
        end
        sb.delete();
        test_basic(40, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic(10, 1'b0, "basic");
        test_basic(10, 1'b1, "backpressure");
        test_overflow();
        test_short();
        test_empty();
        test_coincident();
        test_reset_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter n, default 8: width of matrix dimension inputs.
REQ-002 SHALL have parameter m, default 8: result-buffer address width; buffer depth 2^m words.
REQ-003 SHALL have parameter w, default 16: result data width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-006 SHALL have port loaddim, input, 1: one-cycle strobe from the control unit; latch dimensions and start a job.
REQ-007 SHALL have ports dim0, dim2, input, n each: result rows and result columns.
REQ-008 SHALL have port valid, input, 1: one-cycle strobe; res_data holds one finished dot product.
REQ-009 SHALL have port res_data, input, w: accumulator value qualified by valid.
REQ-010 SHALL have port done, input, 1: one-cycle strobe from the control unit; computation finished.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, w), out_row (output, n), out_col (output, n), out_last (output, 1): drain stream with valid/ready handshake.
REQ-012 SHALL have ports busy (output, 1), drained (output, 1, one-cycle pulse), err_short (output, 1, sticky), err_ovf (output, 1, sticky).

Function
REQ-013 SHALL implement states IDLE, COLLECT, DRAIN; busy=1 in COLLECT and DRAIN.
REQ-014 SHALL, in IDLE on loaddim, latch dim0/dim2, compute total = dim0*dim2 at 2n bits, clear wr_cnt, row, col, err_short, err_ovf, and enter COLLECT next cycle.
REQ-015 SHALL ignore loaddim in COLLECT and DRAIN.
REQ-016 SHALL, in COLLECT on valid with wr_cnt < total and wr_cnt < 2^m, write res_data to buf[wr_cnt], increment wr_cnt, and advance (row, col) in row-major order; col wraps from dim2-1 to 0 and increments row.
REQ-017 SHALL, on valid with wr_cnt >= total or wr_cnt = 2^m, discard data, set err_ovf, and leave wr_cnt unchanged.
REQ-018 SHALL ignore valid outside COLLECT.
REQ-019 SHALL, on done in COLLECT, enter DRAIN next cycle; when valid and done coincide, capture the datum first.
REQ-020 SHALL, on entering DRAIN with wr_cnt != total, set err_short; drain covers only the wr_cnt captured words.
REQ-021 SHALL, in DRAIN with rd_cnt < wr_cnt, drive out_valid=1, out_data=buf[rd_cnt] (combinational read), and out_row/out_col equal to the coordinates of element rd_cnt.
REQ-022 SHALL assert out_last with out_valid when rd_cnt = wr_cnt-1.
REQ-023 SHALL hold out_data, out_row, out_col and out_last stable while out_valid=1 and out_ready=0; advance rd_cnt only on out_valid & out_ready.
REQ-024 SHALL, on acceptance of the out_last beat, pulse drained for one cycle and return to IDLE next cycle.
REQ-025 SHALL, on entering DRAIN with wr_cnt=0 (including dim0=0 or dim2=0), never assert out_valid, pulse drained in the first DRAIN cycle, and return to IDLE.
REQ-026 SHALL ignore done outside COLLECT.
REQ-027 SHALL keep err_short and err_ovf set until the next accepted loaddim or rst.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE from any state, including mid-COLLECT and mid-DRAIN, and abandon the job.
REQ-029 SHALL, on the same reset, set out_valid, out_last, busy, drained, err_short and err_ovf to 0 and clear wr_cnt, rd_cnt, row and col.
REQ-030 SHALL not require the buffer contents to be reset.

Verification
REQ-031 SHALL pass: loaddim dim0=2, dim2=3; valid with data 10..15; done; out_ready=1 -> six beats 10..15; (row, col) (0,0)..(1,2); out_last on beat 15; drained 1 cycle later; no errors.
REQ-032 SHALL pass: same job with out_ready toggled 1/0 each cycle -> identical beat sequence; each beat held stable while stalled.
REQ-033 SHALL pass: dim0=2, dim2=2; four valids, one extra valid 99, then done -> err_ovf=1; 99 absent from the drain; four beats drained.
REQ-034 SHALL pass: dim0=2, dim2=2; three valids then done -> err_short=1; three beats drained; out_last on the third.
REQ-035 SHALL pass: dim0=0, then done -> no out_valid; drained pulse; back in IDLE; the last valid coincident with done is captured.
REQ-036 SHALL pass: rst asserted during DRAIN after two beats -> next cycle IDLE, out_valid=0, busy=0; a following job runs correctly.
